// File: rtl/daq_frame_capture.sv
// daq_frame_capture: samples the camera parallel bus, buffers pixels and emits a framed byte stream.
// Optional `HSYNC_GATE_EN: when defined, pixels are only captured while synchronised hsync is high.
module daq_frame_capture #(
  parameter int unsigned BUF_DEPTH = 8,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  data_in,
  input  logic        pclk,
  input  logic        vsync,
  input  logic        hsync,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [23:0] pixel_cnt,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    FRAME,
    DRAIN
  } state_t;

  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       pclk_s1_d, pclk_s2_d, pclk_s3_d;
  logic       vsync_s1_q, vsync_s2_q, vsync_s3_q;
  logic       vsync_s1_d, vsync_s2_d, vsync_s3_d;
  logic [7:0] data_s1_q, data_s2_q;
  logic [7:0] data_s1_d, data_s2_d;

  logic line_gate;

  state_t      state_q, state_d;
  logic        end_pending_q, end_pending_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [23:0] pixel_cnt_q, pixel_cnt_d;
  logic        overflow_q, overflow_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic [7:0] buf_mem [BUF_DEPTH];

  logic       pclk_rise, vsync_fall, vsync_rise;
  logic       capture, strobe, push, pop;
  logic       buf_empty, buf_full, out_load;
  logic       src_valid;
  logic [7:0] src_data;

  always_comb begin
    pclk_s1_d  = pclk;
    pclk_s2_d  = pclk_s1_q;
    pclk_s3_d  = pclk_s2_q;
    vsync_s1_d = vsync;
    vsync_s2_d = vsync_s1_q;
    vsync_s3_d = vsync_s2_q;
    data_s1_d  = data_in;
    data_s2_d  = data_s1_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pclk_s1_q  <= 1'b0;
      pclk_s2_q  <= 1'b0;
      pclk_s3_q  <= 1'b0;
      vsync_s1_q <= 1'b0;
      vsync_s2_q <= 1'b0;
      vsync_s3_q <= 1'b0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
    end else begin
      pclk_s1_q  <= pclk_s1_d;
      pclk_s2_q  <= pclk_s2_d;
      pclk_s3_q  <= pclk_s3_d;
      vsync_s1_q <= vsync_s1_d;
      vsync_s2_q <= vsync_s2_d;
      vsync_s3_q <= vsync_s3_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
    end
  end

`ifdef HSYNC_GATE_EN
  logic hsync_s1_q, hsync_s2_q;
  logic hsync_s1_d, hsync_s2_d;

  always_comb begin
    hsync_s1_d = hsync;
    hsync_s2_d = hsync_s1_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_s1_q <= 1'b0;
      hsync_s2_q <= 1'b0;
    end else begin
      hsync_s1_q <= hsync_s1_d;
      hsync_s2_q <= hsync_s2_d;
    end
  end

  assign line_gate = hsync_s2_q;
`else
  logic unused_hsync;
  assign unused_hsync = hsync;
  assign line_gate    = 1'b1;
`endif

  // hsync shares the pclk synchroniser depth, so the gate lines up with the detected edge
  assign pclk_rise  = pclk_s2_q & ~pclk_s3_q;
  assign vsync_fall = ~vsync_s2_q & vsync_s3_q;
  assign vsync_rise = vsync_s2_q & ~vsync_s3_q;

  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign out_load  = ~out_valid_q | out_ready;
  assign capture   = (state_q == HDR0) || (state_q == HDR1) || (state_q == HDR2) ||
                     (state_q == HDR3) || (state_q == FRAME);
  assign strobe    = pclk_rise & line_gate & capture;

  always_comb begin
    state_d       = state_q;
    end_pending_d = end_pending_q;
    frame_cnt_d   = frame_cnt_q;
    pixel_cnt_d   = pixel_cnt_q;
    overflow_d    = overflow_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    src_valid     = 1'b0;
    src_data      = '0;
    pop           = 1'b0;
    push          = 1'b0;

    case (state_q)
      IDLE: begin
        if (vsync_fall) begin
          state_d       = HDR0;
          frame_cnt_d   = frame_cnt_q + 16'd1;
          pixel_cnt_d   = '0;
          overflow_d    = 1'b0;
          frame_start_d = 1'b1;
          end_pending_d = 1'b0;
        end
      end
      HDR0: begin
        src_valid = 1'b1;
        src_data  = SYNC_WORD[15:8];
        if (out_load) state_d = HDR1;
      end
      HDR1: begin
        src_valid = 1'b1;
        src_data  = SYNC_WORD[7:0];
        if (out_load) state_d = HDR2;
      end
      HDR2: begin
        src_valid = 1'b1;
        src_data  = frame_cnt_q[15:8];
        if (out_load) state_d = HDR3;
      end
      HDR3: begin
        src_valid = 1'b1;
        src_data  = frame_cnt_q[7:0];
        if (out_load) state_d = (end_pending_q || vsync_rise) ? DRAIN : FRAME;
      end
      FRAME: begin
        src_valid = ~buf_empty;
        src_data  = buf_mem[rd_ptr_q[AW-1:0]];
        pop       = out_load & ~buf_empty;
        if (vsync_rise) state_d = DRAIN;
      end
      DRAIN: begin
        src_valid = ~buf_empty;
        src_data  = buf_mem[rd_ptr_q[AW-1:0]];
        pop       = out_load & ~buf_empty;
        if (buf_empty && out_load) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A short frame may end before the header is out; remember it until HDR3 completes
    if (capture && (state_q != FRAME) && vsync_rise) end_pending_d = 1'b1;

    push = strobe & (~buf_full | pop);
    if (strobe) begin
      pixel_cnt_d = (pixel_cnt_q == 24'hFFFFFF) ? pixel_cnt_q : pixel_cnt_q + 24'd1;
      if (!push) overflow_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};

    if (out_load) begin
      out_valid_d = src_valid;
      if (src_valid) out_data_d = src_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      end_pending_q <= 1'b0;
      frame_cnt_q   <= '0;
      pixel_cnt_q   <= '0;
      overflow_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      end_pending_q <= end_pending_d;
      frame_cnt_q   <= frame_cnt_d;
      pixel_cnt_q   <= pixel_cnt_d;
      overflow_q    <= overflow_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge sys_clk) begin
    if (push) buf_mem[wr_ptr_q[AW-1:0]] <= data_s2_q;
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign pixel_cnt   = pixel_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_daq_frame_capture.sv
// Testbench for daq_frame_capture: table-driven frames, randomized frames against a stream model,
// and hand-written sequences for latency, header-time frame end, hsync gating, wrap and reset.
`timescale 1ns/1ps
module tb_daq_frame_capture;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  data_in;
  logic        pclk;
  logic        vsync;
  logic        hsync;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_start;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [23:0] pixel_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;
  int done_pulses = 0;
  bit rand_ready_en = 1'b0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];

  typedef struct {
    int npix;
    bit stall;
    int exp_bytes;
    bit exp_ovf;
  } vec_t;

  daq_frame_capture #(.BUF_DEPTH(8), .SYNC_WORD(16'hA55A)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .data_in     (data_in),
    .pclk        (pclk),
    .vsync       (vsync),
    .hsync       (hsync),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .pixel_cnt   (pixel_cnt),
    .overflow    (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Collect accepted bytes and count pulses on the falling edge, away from the active edge
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_start) start_pulses++;
      if (frame_done) done_pulses++;
    end
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One camera pixel: data/hsync settle, then a pclk pulse of 3 high and 2 low cycles
  task automatic applyStimulus(input byte unsigned d, input bit hs);
    data_in = d;
    hsync   = hs;
    tick(1);
    pclk = 1'b1;
    tick(3);
    pclk = 1'b0;
    tick(2);
  endtask

  task automatic waitStart(input string name);
    int n0 = start_pulses;
    int k = 0;
    while (start_pulses == n0 && k < 20) begin
      tick(1);
      k++;
    end
    checkOutput({name, " frame_start seen"}, 32'(start_pulses != n0), 32'd1);
  endtask

  task automatic waitDone(input string name);
    int n0 = done_pulses;
    int k = 0;
    while (done_pulses == n0 && k < 400) begin
      tick(1);
      k++;
    end
    tick(3);
    checkOutput({name, " frame_done pulses"}, 32'(done_pulses - n0), 32'd1);
  endtask

  task automatic expectHeader(input logic [15:0] fc);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(fc[15:8]);
    exp_q.push_back(fc[7:0]);
  endtask

  task automatic compareStream(input string name);
    checkOutput({name, " length"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin : main
    vec_t vecs[4];
    logic [15:0] exp_fc;
    byte unsigned base;
    byte unsigned d;
    int k;
    int npix;
    int s0;
    int exp_pix;

    sys_rst_n = 1'b0;
    data_in   = 8'h00;
    pclk      = 1'b0;
    vsync     = 1'b1;
    hsync     = 1'b1;
    out_ready = 1'b1;
    exp_fc    = 16'd0;
    tick(3);

    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset pixel_cnt", 32'(pixel_cnt), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);

    sys_rst_n = 1'b1;
    tick(6);

    vecs[0] = '{npix: 6,  stall: 1'b0, exp_bytes: 6, exp_ovf: 1'b0};
    vecs[1] = '{npix: 12, stall: 1'b1, exp_bytes: 8, exp_ovf: 1'b1};
    vecs[2] = '{npix: 1,  stall: 1'b0, exp_bytes: 1, exp_ovf: 1'b0};
    vecs[3] = '{npix: 0,  stall: 1'b0, exp_bytes: 0, exp_ovf: 1'b0};

    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      exp_q.delete();
      base      = 8'(8'h10 + 8'(i * 32));
      out_ready = ~vecs[i].stall;
      vsync     = 1'b0;
      waitStart($sformatf("vec%0d", i));
      exp_fc++;
      for (int p = 0; p < vecs[i].npix; p++) applyStimulus(8'(base + 8'(p)), 1'b1);
      vsync = 1'b1;
      tick(4);
      out_ready = 1'b1;
      waitDone($sformatf("vec%0d", i));
      expectHeader(exp_fc);
      for (int p = 0; p < vecs[i].exp_bytes; p++) exp_q.push_back(8'(base + 8'(p)));
      compareStream($sformatf("vec%0d stream", i));
      checkOutput($sformatf("vec%0d pixel_cnt", i), 32'(pixel_cnt), 32'(vecs[i].npix));
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d frame_cnt", i), 32'(frame_cnt), 32'(exp_fc));
    end

    // Randomized frames with random back-pressure; the model is the expected byte order
    rand_ready_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      got_q.delete();
      exp_q.delete();
      npix  = $urandom_range(0, 16);
      vsync = 1'b0;
      waitStart($sformatf("rand%0d", f));
      exp_fc++;
      expectHeader(exp_fc);
      for (int p = 0; p < npix; p++) begin
        d = 8'($urandom);
        exp_q.push_back(d);
        applyStimulus(d, 1'b1);
      end
      tick($urandom_range(0, 4));
      vsync = 1'b1;
      waitDone($sformatf("rand%0d", f));
      compareStream($sformatf("rand%0d stream", f));
      checkOutput($sformatf("rand%0d pixel_cnt", f), 32'(pixel_cnt), 32'(npix));
      checkOutput($sformatf("rand%0d overflow", f), 32'(overflow), 32'd0);
      checkOutput($sformatf("rand%0d frame_cnt", f), 32'(frame_cnt), 32'(exp_fc));
    end
    rand_ready_en = 1'b0;
    out_ready     = 1'b1;
    tick(4);

    // Latencies: vsync fall to frame_start, frame_start to HDR0, pclk rise to out_data
    vsync = 1'b0;
    k = 0;
    while (!frame_start && k < 10) begin
      tick(1);
      k++;
    end
    exp_fc++;
    checkOutput("vsync to frame_start edges", 32'(k), 32'd3);
    checkOutput("hdr0 not yet valid", 32'(out_valid), 32'd0);
    tick(1);
    checkOutput("hdr0 valid after 1 cycle", 32'(out_valid), 32'd1);
    checkOutput("hdr0 byte", 32'(out_data), 32'hA5);
    tick(8);
    data_in = 8'h77;
    tick(1);
    pclk = 1'b1;
    k = 0;
    while (!(out_valid && out_data == 8'h77) && k < 10) begin
      tick(1);
      k++;
    end
    checkOutput("pclk to out_data cycles", 32'(k), 32'd4);
    pclk = 1'b0;
    tick(2);
    vsync = 1'b1;
    waitDone("latency");
    checkOutput("latency pixel_cnt", 32'(pixel_cnt), 32'd1);

    // Frame ends while the header is stalled in HDR1
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b0;
    vsync     = 1'b0;
    waitStart("hdr1 end");
    exp_fc++;
    s0 = done_pulses;
    tick(2);
    checkOutput("hdr1 held valid", 32'(out_valid), 32'd1);
    checkOutput("hdr1 held data", 32'(out_data), 32'hA5);
    applyStimulus(8'hC1, 1'b1);
    applyStimulus(8'hC2, 1'b1);
    vsync = 1'b1;
    tick(6);
    checkOutput("hdr1 no early frame_done", 32'(done_pulses - s0), 32'd0);
    out_ready = 1'b1;
    waitDone("hdr1 end");
    expectHeader(exp_fc);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    compareStream("hdr1 end stream");
    checkOutput("hdr1 end pixel_cnt", 32'(pixel_cnt), 32'd2);

    // hsync gating: 4 pixels with hsync low, then 3 with hsync high
    got_q.delete();
    exp_q.delete();
    vsync = 1'b0;
    waitStart("hsync");
    exp_fc++;
    expectHeader(exp_fc);
    for (int p = 0; p < 7; p++) applyStimulus(8'(8'h40 + 8'(p)), p >= 4);
    hsync = 1'b1;
`ifdef HSYNC_GATE_EN
    exp_pix = 3;
    for (int p = 4; p < 7; p++) exp_q.push_back(8'(8'h40 + 8'(p)));
`else
    exp_pix = 7;
    for (int p = 0; p < 7; p++) exp_q.push_back(8'(8'h40 + 8'(p)));
`endif
    vsync = 1'b1;
    waitDone("hsync");
    compareStream("hsync stream");
    checkOutput("hsync pixel_cnt", 32'(pixel_cnt), 32'(exp_pix));

    // frame_cnt wrap from 16'hFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    tick(2);
    release dut.frame_cnt_q;
    tick(1);
    exp_fc = 16'hFFFF;
    got_q.delete();
    exp_q.delete();
    vsync = 1'b0;
    waitStart("wrap");
    exp_fc++;
    expectHeader(exp_fc);
    applyStimulus(8'h5E, 1'b1);
    exp_q.push_back(8'h5E);
    vsync = 1'b1;
    waitDone("wrap");
    compareStream("wrap stream");
    checkOutput("wrap frame_cnt", 32'(frame_cnt), 32'd0);

    // Reset in the middle of a frame with bytes buffered
    vsync = 1'b0;
    waitStart("midreset");
    tick(8);
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) applyStimulus(8'(8'h90 + 8'(p)), 1'b1);
    checkOutput("midreset pending valid", 32'(out_valid), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_data", 32'(out_data), 32'd0);
    checkOutput("midreset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("midreset pixel_cnt", 32'(pixel_cnt), 32'd0);
    checkOutput("midreset overflow", 32'(overflow), 32'd0);
    tick(2);
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    s0 = start_pulses;
    for (int p = 0; p < 3; p++) applyStimulus(8'(8'hB0 + 8'(p)), 1'b1);
    tick(10);
    checkOutput("post-reset no frame_start", 32'(start_pulses - s0), 32'd0);
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("post-reset pixel_cnt", 32'(pixel_cnt), 32'd0);
    checkOutput("post-reset stream empty", 32'(got_q.size()), 32'd0);
    vsync = 1'b1;
    tick(5);
    vsync = 1'b0;
    waitStart("post-reset");
    exp_fc = 16'd1;
    expectHeader(exp_fc);
    vsync = 1'b1;
    waitDone("post-reset");
    compareStream("post-reset stream");
    checkOutput("post-reset frame_cnt", 32'(frame_cnt), 32'(exp_fc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
